// File: rtl/calc_seq_resp_if.sv
// Request/response bus for the sequential three-operand calculator.
// The requester drives operands and rsp_ready; the responder drives
// req_ready, rsp_valid and the result.
interface calc_seq_resp_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic [1:0] op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] R;
    logic       C_out;

    modport master (
        output req_valid, A, B, C, op, rsp_ready,
        input  req_ready, rsp_valid, R, C_out
    );

    modport slave (
        input  req_valid, A, B, C, op, rsp_ready,
        output req_ready, rsp_valid, R, C_out
    );
endinterface

// File: rtl/calc_seq_resp.sv
// Sequential responder for the 8-bit three-operand calculator.
// Accepts one request at a time, evaluates it in EXEC (one cycle, or
// MUL_STEPS cycles of LSB-first shift-add for a multiply), then holds
// the result in DONE until the requester takes it.
module calc_seq_resp #(
    parameter int MUL_STEPS = 8
) (
    input  logic           clk,
    input  logic           rst,
    calc_seq_resp_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b10;
    localparam int         STEP_W   = $clog2(MUL_STEPS + 1);

    state_t state;
    state_t state_next;

    logic              accept;
    logic              exec_done;
    logic              last_step;
    logic              rsp_valid_q;

    // Operands latched on accept; later input changes are ignored.
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [7:0]        c_q;
    logic [1:0]        op_q;

    // Shift-add multiplier: multiplicand shifts left, multiplier shifts
    // right so bit 0 always holds the multiplier bit of the current step.
    logic [15:0]       acc_q;
    logic [15:0]       acc_next;
    logic [15:0]       mcand_q;
    logic [7:0]        mplier_q;
    logic [STEP_W-1:0] step_q;

    logic [9:0]        sum;
    logic [8:0]        diff;
    logic [7:0]        res_r;
    logic              res_c;
    logic [7:0]        r_q;
    logic              c_out_q;

    assign last_step     = (step_q == STEP_W'(MUL_STEPS - 1));
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.R         = r_q;
    assign bus.C_out     = c_out_q;

    // State register; reset abandons any transaction in flight.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the accept/complete strobes.
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        exec_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (op_q != OP_MUL || last_step) begin
                    exec_done  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered response-valid, high exactly while the FSM sits in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= (state_next == DONE);
        end
    end

    // Result arithmetic from the latched operands; the multiply result is
    // taken from the accumulator value the final step produces.
    always_comb begin
        sum      = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        acc_next = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
        res_r    = 8'h00;
        res_c    = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_r = sum[7:0];
                res_c = |sum[9:8];
            end
            OP_SUB: begin
                res_r = diff[7:0];
                res_c = diff[8];
            end
            OP_MUL: begin
                res_r = acc_next[7:0];
                res_c = |acc_next[15:8];
            end
            default: begin
                res_r = (a_q & b_q) | c_q;
                res_c = 1'b0;
            end
        endcase
    end

    // Operand capture, multiply iteration, and result write on EXEC exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 8'h00;
            op_q     <= OP_ADD;
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            step_q   <= '0;
            r_q      <= 8'h00;
            c_out_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= bus.A;
                b_q      <= bus.B;
                c_q      <= bus.C;
                op_q     <= bus.op;
                acc_q    <= 16'h0000;
                mcand_q  <= {8'h00, bus.A};
                mplier_q <= bus.B;
                step_q   <= '0;
            end else if (state == EXEC && op_q == OP_MUL) begin
                acc_q    <= acc_next;
                mcand_q  <= {mcand_q[14:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[7:1]};
                step_q   <= step_q + STEP_W'(1);
            end
            if (exec_done) begin
                r_q     <= res_r;
                c_out_q <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_resp.sv
// Self-checking bench for calc_seq_resp: directed cases for each op and
// the handshake corner cases, then randomized transactions against an
// arithmetic reference model.
module tb_calc_seq_resp;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    calc_seq_resp_if bus ();

    calc_seq_resp #(.MUL_STEPS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry, result} straight from the operation definitions.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [1:0] op);
        int s;
        int p;
        case (op)
            2'b00: begin
                s = int'(a) + int'(b) + int'(c);
                return {s > 255, s[7:0]};
            end
            2'b01: begin
                s = int'(a) - int'(b);
                return {a < b, s[7:0]};
            end
            2'b10: begin
                p = int'(a) * int'(b);
                return {p > 255, p[7:0]};
            end
            default: return {1'b0, (a & b) | c};
        endcase
    endfunction

    // One complete transaction: accept, count edges until rsp_valid,
    // capture the result, then take it after 'hold' extra cycles.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [1:0] op, input int hold,
                           output logic [7:0] r, output logic co, output int lat);
        bus.A         = a;
        bus.B         = b;
        bus.C         = c;
        bus.op        = op;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r  = bus.R;
        co = bus.C_out;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.A = 8'h00; bus.B = 8'h00; bus.C = 8'h00; bus.op = 2'b00;
        rst = 1'b0;
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.rsp_valid, bus.req_ready, bus.C_out, bus.R} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_async: rsp_valid/req_ready/C_out/R = %b/%b/%b/%h, want 0/1/0/00",
                     bus.rsp_valid, bus.req_ready, bus.C_out, bus.R);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_add();
        logic [7:0] va[4] = '{8'd200, 8'd1, 8'hFF, 8'h00};
        logic [7:0] vb[4] = '{8'd100, 8'd2, 8'hFF, 8'h00};
        logic [7:0] vc[4] = '{8'd10,  8'd3, 8'hFF, 8'h00};
        logic [8:0] ve[4] = '{9'h136, 9'h006, 9'h1FD, 9'h000};
        logic [7:0] r;
        logic       co;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run_txn(va[i], vb[i], vc[i], 2'b00, 0, r, co, lat);
            tests_run++;
            if ({co, r} !== ve[i]) begin
                tests_failed++;
                $display("FAIL add_%0d: {C_out,R} = %h, want %h", i, {co, r}, ve[i]);
            end
            tests_run++;
            if (lat !== 1) begin
                tests_failed++;
                $display("FAIL add_latency_%0d: %0d edges, want 1", i, lat);
            end
        end
    endtask

    task automatic test_sub_logic();
        logic [1:0] vo[4] = '{2'b01, 2'b01, 2'b11, 2'b01};
        logic [7:0] va[4] = '{8'd5, 8'd7, 8'hF0, 8'd9};
        logic [7:0] vb[4] = '{8'd7, 8'd5, 8'h3C, 8'd9};
        logic [7:0] vc[4] = '{8'h00, 8'h00, 8'h01, 8'hAA};
        logic [8:0] ve[4] = '{9'h1FE, 9'h002, 9'h031, 9'h000};
        logic [7:0] r;
        logic       co;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run_txn(va[i], vb[i], vc[i], vo[i], 1, r, co, lat);
            tests_run++;
            if ({co, r} !== ve[i] || lat !== 1) begin
                tests_failed++;
                $display("FAIL sub_logic_%0d: {C_out,R} = %h lat %0d, want %h lat 1",
                         i, {co, r}, lat, ve[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] va[5] = '{8'd15, 8'd16, 8'hFF, 8'h00, 8'h5A};
        logic [7:0] vb[5] = '{8'd17, 8'd16, 8'hFF, 8'hAB, 8'h00};
        logic [8:0] ve[5] = '{9'h0FF, 9'h100, 9'h101, 9'h000, 9'h000};
        logic [7:0] r;
        logic       co;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            run_txn(va[i], vb[i], 8'h77, 2'b10, 0, r, co, lat);
            tests_run++;
            if ({co, r} !== ve[i]) begin
                tests_failed++;
                $display("FAIL mul_%0d: {C_out,R} = %h, want %h", i, {co, r}, ve[i]);
            end
            tests_run++;
            if (lat !== 8) begin
                tests_failed++;
                $display("FAIL mul_latency_%0d: %0d edges, want 8", i, lat);
            end
        end
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_release: req_ready %b rsp_valid %b, want 1 0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        bus.A = 8'd15; bus.B = 8'd17; bus.C = 8'h00; bus.op = 2'b10;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        bad = 0;
        // req_valid stays high and operands churn through EXEC.
        while (!bus.rsp_valid && lat < 40) begin
            bus.A  = 8'($urandom);
            bus.B  = 8'($urandom);
            bus.C  = 8'($urandom);
            bus.op = 2'($urandom);
            if (bus.req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat !== 8 || bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_exec: latency %0d ready-high cycles %0d, want 8 and 0", lat, bad);
        end
        tests_run++;
        if ({bus.C_out, bus.R} !== 9'h0FF) begin
            tests_failed++;
            $display("FAIL bp_result: {C_out,R} = %h, want 0ff", {bus.C_out, bus.R});
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.R !== 8'hFF || bus.C_out !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_stall: %0d of 5 stalled cycles disturbed, want 0", bad);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        tests_run++;
        if ({bus.rsp_valid, bus.req_ready, bus.C_out, bus.R} !== {1'b0, 1'b1, 1'b0, 8'hFF}) begin
            tests_failed++;
            $display("FAIL bp_release: rsp_valid/req_ready/C_out/R = %b/%b/%b/%h, want 0/1/0/ff",
                     bus.rsp_valid, bus.req_ready, bus.C_out, bus.R);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_no_second_accept: %0d busy cycles after release, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] r;
        logic       co;
        int         lat;
        int         bad;
        bus.A = 8'h37; bus.B = 8'hC9; bus.C = 8'h00; bus.op = 2'b10;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.rsp_valid, bus.req_ready, bus.C_out, bus.R} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_mid_mul: rsp_valid/req_ready/C_out/R = %b/%b/%b/%h, want 0/1/0/00",
                     bus.rsp_valid, bus.req_ready, bus.C_out, bus.R);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL reset_discard: %0d cycles with stale activity, want 0", bad);
        end
        run_txn(8'd1, 8'd1, 8'd1, 2'b00, 0, r, co, lat);
        tests_run++;
        if ({co, r} !== 9'h003 || lat !== 1) begin
            tests_failed++;
            $display("FAIL reset_recover: {C_out,R} = %h lat %0d, want 003 lat 1", {co, r}, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        int         accepts[$];
        logic       was_ready;
        logic [8:0] exp;
        int         bad;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int e = 0; e < 12; e++) begin
            if (e == 0 || was_ready) begin
                bus.A  = 8'($urandom);
                bus.B  = 8'($urandom);
                bus.C  = 8'($urandom);
                bus.op = 2'($urandom_range(0, 2));
                if (bus.op == 2'b10) bus.op = 2'b11;
            end
            was_ready = bus.req_ready;
            if (was_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.C, bus.op));
                accepts.push_back(e);
            end
            if (e == 10) bus.req_valid = 1'b0;
            @(posedge clk); #1;
            if (bus.rsp_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                tests_run++;
                if ({bus.C_out, bus.R} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b_result_edge%0d: {C_out,R} = %h, want %h",
                             e, {bus.C_out, bus.R}, exp);
                end
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bad = 0;
        foreach (accepts[k]) if (accepts[k] != 3 * k) bad++;
        tests_run++;
        if (accepts.size() != 4 || bad != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d accepts, %0d off-grid, %0d unanswered, want 4 0 0",
                     accepts.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, c, r;
        logic [1:0] op;
        logic       co;
        logic [8:0] exp;
        int         lat;
        for (int i = 0; i < 40; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            c   = 8'($urandom);
            op  = 2'($urandom);
            exp = model(a, b, c, op);
            run_txn(a, b, c, op, int'($urandom_range(0, 3)), r, co, lat);
            tests_run++;
            if ({co, r} !== exp || lat !== ((op == 2'b10) ? 8 : 1)) begin
                tests_failed++;
                $display("FAIL random_%0d op%b %h,%h,%h: {C_out,R} = %h lat %0d, want %h lat %0d",
                         i, op, a, b, c, {co, r}, lat, exp, (op == 2'b10) ? 8 : 1);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_sub_logic();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
